sdram_arbiter: RTL and testbench
================================

Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller command port between three requesters: CHR fetch (PPU side), PRG fetch (CPU side) and the MCU loader/aux channel.
- Each requester uses a toggle req/ack handshake, the same style as the mapper-control path. The arbiter grants one request at a time, issues it to the SDRAM controller, waits for completion, returns read data and toggles ack.
- Sits between the prg_ram/chr_ram front-ends plus the loader and the SDRAM controller.
- All requesters are in the clk domain; any synchronisation happens upstream.

Parameters:
- ADDR_BITS, 22, SDRAM word address width.
- DATA_BITS, 16, SDRAM data width.
- STARVE_MAX, 8, consecutive CHR/PRG grants allowed while AUX is pending before AUX is forced.
- TIMEOUT, 64, cycles to wait for mem_done (used only with SDRAM_ARB_TIMEOUT_EN).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- req  in  3  per-channel request toggle; index 0 = CHR, 1 = PRG, 2 = AUX.
- ack  out  3  per-channel ack toggle.
- we  in  3  per-channel write enable.
- addr  in  3×ADDR_BITS  per-channel word address.
- wdata  in  3×DATA_BITS  per-channel write data.
- wmask  in  3×(DATA_BITS/8)  per-channel byte-enable mask, 1 = write byte.
- rdata  out  3×DATA_BITS  per-channel read data; held until that channel's next completion.
- mem_valid  out  1  command valid to controller.
- mem_ready  in  1  controller accepts command.
- mem_we  out  1  command write.
- mem_addr  out  ADDR_BITS  command address.
- mem_wdata  out  DATA_BITS  command write data.
- mem_wmask  out  DATA_BITS/8  command byte mask.
- mem_done  in  1  one-cycle completion pulse.
- mem_rdata  in  DATA_BITS  read data, valid with mem_done.
- busy  out  1  state != IDLE.
- err  out  1  sticky timeout flag; constant 0 without SDRAM_ARB_TIMEOUT_EN.

Behaviour:
- Reset: clock and reset are decided: one clock `clk`; reset `reset_n` is synchronous and active-low. While reset_n = 0 at a clk edge:
  - ack = 0, rdata = 0, mem_valid = 0, mem_* = 0, err = 0.
  - state = IDLE, starve_cnt = 0, grant register = 0.
- Pending: channel i is pending when req[i] != ack[i]. The requester must hold we/addr/wdata/wmask stable while pending, and must not toggle req again until ack matches.
- FSM:
  - IDLE: if any channel is pending, choose a grant:
    - If AUX is pending and starve_cnt == STARVE_MAX, grant AUX.
    - Otherwise use fixed priority CHR > PRG > AUX.
    - Latch the grant index. Drive mem_valid = 1 with the granted channel's fields, registered, so mem_valid rises the cycle after IDLE sees the pending request. Go to ISSUE.
  - ISSUE: hold mem_valid and the command stable until mem_ready = 1. On that edge, drop mem_valid and go to WAIT.
  - WAIT: on mem_done:
    - Reads: rdata[grant] <= mem_rdata. Writes: rdata[grant] is unchanged.
    - ack[grant] <= req[grant] (toggle).
    - Return to IDLE.
    - Ack is visible one cycle after mem_done.
- mem_done in IDLE or ISSUE is ignored. This includes a stale pulse arriving after reset mid-operation.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each CHR or PRG grant while AUX is pending.
  - Clears on an AUX grant, or in IDLE when AUX is not pending.
- Simultaneous events:
  - A new req toggle arriving in the same cycle as another channel's ack is seen in the next IDLE.
  - Back-to-back throughput: IDLE → ISSUE → WAIT → IDLE, minimum 3 cycles plus controller latency.
- No combinational path from req to mem_valid, or from mem_done to ack.

Optional Feature:
- Macro: SDRAM_ARB_TIMEOUT_EN.
- Defined:
  - A WAIT-state cycle counter counts cycles in WAIT.
  - If it reaches TIMEOUT without mem_done: set err (sticky until reset), ack the granted channel with rdata = all ones for reads, and return to IDLE.
  - The counter clears on entry to WAIT.
- Undefined: WAIT persists until mem_done; err is tied to 0; no counter logic is present.

Decomposition:
- Package sdram_arb_pkg:
  - Channel index constants CH_CHR = 0, CH_PRG = 1, CH_AUX = 2 and N_CH = 3.
  - State enum arb_state_t {IDLE, ISSUE, WAIT}.
  - Packed struct mem_cmd_t {we, addr, wdata, wmask}.
- One natural sub-module: sdram_arb_pick. Purely combinational priority/starvation selector taking pending[2:0] and starve_force, returning grant_valid and grant_idx.

Test Plan:
- Single CHR read: toggle req[0] with addr = 0x000123; controller gives ready after 2 cycles and done after 4 more with rdata 0xBEEF → exactly one mem_valid command with mem_addr 0x000123, mem_we = 0; ack[0] toggles one cycle after done; rdata[0] = 0xBEEF.
- Simultaneous CHR, PRG and AUX requests in one cycle → grant order CHR, PRG, AUX; three sequential commands; each ack toggles only after its own done.
- Starvation: keep CHR and PRG continuously re-requesting while AUX is pending, STARVE_MAX = 8 → AUX is granted as the 9th command; starve_cnt returns to 0.
- PRG write: wdata 0x00A5, wmask 2'b01 → mem_we = 1, mem_wmask = 01; rdata[1] unchanged; ack[1] toggles.
- Reset mid-WAIT: assert reset_n = 0 for one cycle, then deliver a stray mem_done → ack = 0, state IDLE, no ack toggle, rdata unchanged at 0.
- With SDRAM_ARB_TIMEOUT_EN and TIMEOUT = 64: withhold mem_done → at cycle 64 of WAIT, err = 1, ack toggles, rdata = 0xFFFF; the next request is still serviced normally and err stays 1.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the three-channel SDRAM command arbiter: channel indices,
// FSM state encoding and the command record handed to the SDRAM controller.
package sdram_arb_pkg;

  localparam int N_CH   = 3;
  localparam int CH_CHR = 0;
  localparam int CH_PRG = 1;
  localparam int CH_AUX = 2;

  localparam int ARB_ADDR_BITS = 22;
  localparam int ARB_DATA_BITS = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  // Sized for the default SDRAM geometry used by the arbiter.
  typedef struct packed {
    logic                         we;
    logic [ARB_ADDR_BITS-1:0]     addr;
    logic [ARB_DATA_BITS-1:0]     wdata;
    logic [ARB_DATA_BITS/8-1:0]   wmask;
  } mem_cmd_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational grant selector: fixed priority CHR > PRG > AUX, except that a
// starving AUX request wins outright when starve_force is raised.
module sdram_arb_pick
  import sdram_arb_pkg::*;
(
  input  logic [N_CH-1:0] pending,
  input  logic            starve_force,
  output logic            grant_valid,
  output logic [1:0]      grant_idx
);

  always_comb begin
    grant_valid = |pending;
    grant_idx   = 2'd0;
    if (pending[CH_AUX] && starve_force) begin
      grant_idx = 2'(CH_AUX);
    end else if (pending[CH_CHR]) begin
      grant_idx = 2'(CH_CHR);
    end else if (pending[CH_PRG]) begin
      grant_idx = 2'(CH_PRG);
    end else if (pending[CH_AUX]) begin
      grant_idx = 2'(CH_AUX);
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates CHR, PRG and AUX toggle-handshake requesters onto one SDRAM command port.
// Optional WAIT-state timeout with sticky err is enabled by defining SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_BITS  = ARB_ADDR_BITS,
  parameter int DATA_BITS  = ARB_DATA_BITS,
  parameter int STARVE_MAX = 8
`ifdef SDRAM_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT    = 64
`endif
)
(
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [N_CH-1:0]                      req,
  output logic [N_CH-1:0]                      ack,
  input  logic [N_CH-1:0]                      we,
  input  logic [N_CH-1:0][ADDR_BITS-1:0]       addr,
  input  logic [N_CH-1:0][DATA_BITS-1:0]       wdata,
  input  logic [N_CH-1:0][DATA_BITS/8-1:0]     wmask,
  output logic [N_CH-1:0][DATA_BITS-1:0]       rdata,
  output logic                                 mem_valid,
  input  logic                                 mem_ready,
  output logic                                 mem_we,
  output logic [ADDR_BITS-1:0]                 mem_addr,
  output logic [DATA_BITS-1:0]                 mem_wdata,
  output logic [DATA_BITS/8-1:0]               mem_wmask,
  input  logic                                 mem_done,
  input  logic [DATA_BITS-1:0]                 mem_rdata,
  output logic                                 busy,
  output logic                                 err
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_t      state;
  logic [1:0]      grant;
  logic [SW-1:0]   starve_cnt;
  logic [N_CH-1:0] pending;
  logic            starve_force;
  logic            pick_valid;
  logic [1:0]      pick_idx;
  mem_cmd_t        sel_cmd;
  logic            timeout_now;
  logic            complete;
  logic [DATA_BITS-1:0] result_data;

  assign pending      = req ^ ack;
  assign starve_force = (starve_cnt == SW'(STARVE_MAX));
  assign busy         = (state != IDLE);
  assign complete     = (state == WAIT) && (mem_done || timeout_now);
  assign result_data  = timeout_now ? '1 : mem_rdata;

  sdram_arb_pick u_pick (
    .pending      (pending),
    .starve_force (starve_force),
    .grant_valid  (pick_valid),
    .grant_idx    (pick_idx)
  );

  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (pick_idx == 2'(i)) begin
        sel_cmd.we    = we[i];
        sel_cmd.addr  = addr[i];
        sel_cmd.wdata = wdata[i];
        sel_cmd.wmask = wmask[i];
      end
    end
  end

  // The command is registered in IDLE so mem_valid never depends combinationally on req.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= 2'd0;
      starve_cnt <= '0;
      mem_valid  <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wmask  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!pending[CH_AUX]) begin
            starve_cnt <= '0;
          end else if (pick_valid) begin
            if (pick_idx == 2'(CH_AUX)) begin
              starve_cnt <= '0;
            end else if (!starve_force) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
          if (pick_valid) begin
            grant     <= pick_idx;
            mem_valid <= 1'b1;
            mem_we    <= sel_cmd.we;
            mem_addr  <= sel_cmd.addr;
            mem_wdata <= sel_cmd.wdata;
            mem_wmask <= sel_cmd.wmask;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (complete) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completion: reads capture data, writes leave rdata alone; ack follows req for the grant.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack   <= '0;
      rdata <= '0;
    end else if (complete) begin
      for (int i = 0; i < N_CH; i++) begin
        if (grant == 2'(i)) begin
          ack[i] <= req[i];
          if (!mem_we) begin
            rdata[i] <= result_data;
          end
        end
      end
    end
  end

`ifdef SDRAM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;
  logic          err_q;

  assign timeout_now = (state == WAIT) && !mem_done && (wait_cnt == TW'(TIMEOUT - 1));
  assign err         = err_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ISSUE && mem_ready) begin
        wait_cnt <= '0;
      end else if (state == WAIT && !complete) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (timeout_now) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_now = 1'b0;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: behavioural SDRAM controller, vector table plus scoreboard,
// hand sequences for priority, starvation, reset mid-WAIT and (with SDRAM_ARB_TIMEOUT_EN) timeout.
`timescale 1ns/1ps
module tb_sdram_arbiter;
  import sdram_arb_pkg::*;

  localparam int AB = 22;
  localparam int DB = 16;
  localparam int MB = 2;

  typedef struct {
    int          ch;
    logic        we;
    logic [AB-1:0] addr;
    logic [DB-1:0] wdata;
    logic [MB-1:0] wmask;
    logic [DB-1:0] rdata;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [2:0]           req;
  logic [2:0]           ack;
  logic [2:0]           we;
  logic [2:0][AB-1:0]   addr;
  logic [2:0][DB-1:0]   wdata;
  logic [2:0][MB-1:0]   wmask;
  logic [2:0][DB-1:0]   rdata;
  logic                 mem_valid;
  logic                 mem_ready = 1'b0;
  logic                 mem_we;
  logic [AB-1:0]        mem_addr;
  logic [DB-1:0]        mem_wdata;
  logic [MB-1:0]        mem_wmask;
  logic                 mem_done = 1'b0;
  logic [DB-1:0]        mem_rdata = '0;
  logic                 busy;
  logic                 err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  vec_t     exp_q[$];
  mem_cmd_t cmd_log[256];
  int       cmd_wr = 0;
  int       cmd_rd = 0;
  int       last_done_cyc = -100;
  logic     hold_done  = 1'b0;
  logic     stray_req  = 1'b0;
  logic     stray_ack  = 1'b0;
  logic     chk_timing = 1'b1;
  int       rsp_phase  = 0;
  int       rcnt       = 0;
  logic [AB-1:0] cap_addr = '0;

  localparam int NV = 7;
  vec_t tbl[NV];

  sdram_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .ack       (ack),
    .we        (we),
    .addr      (addr),
    .wdata     (wdata),
    .wmask     (wmask),
    .rdata     (rdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .mem_done  (mem_done),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DB-1:0] mem_model(input logic [AB-1:0] a);
    return (a == 22'h000123) ? 16'hBEEF : (a[15:0] ^ 16'h5A5A);
  endfunction

  // Controller model: ready two cycles after valid, done a few cycles after acceptance.
  always @(negedge clk) begin
    mem_done = 1'b0;
    if (!reset_n) begin
      rsp_phase = 0;
      mem_ready = 1'b0;
    end else begin
      if (stray_req != stray_ack) begin
        stray_ack = stray_req;
        mem_done  = 1'b1;
        mem_rdata = 16'hDEAD;
      end
      case (rsp_phase)
        0: if (mem_valid) begin
          rcnt      = 2;
          rsp_phase = 1;
        end
        1: if (rcnt <= 1) begin
          mem_ready = 1'b1;
          cap_addr  = mem_addr;
          if (cmd_wr < 256) cmd_log[cmd_wr] = '{we: mem_we, addr: mem_addr, wdata: mem_wdata, wmask: mem_wmask};
          cmd_wr++;
          rsp_phase = 2;
        end else begin
          rcnt--;
        end
        2: begin
          mem_ready = 1'b0;
          rcnt      = 4;
          rsp_phase = 3;
        end
        default: if (rcnt <= 1) begin
          if (!hold_done) begin
            mem_done      = 1'b1;
            mem_rdata     = mem_model(cap_addr);
            last_done_cyc = cyc;
          end
          rsp_phase = 0;
        end else begin
          rcnt--;
        end
      endcase
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input bit push);
    we[v.ch]    = v.we;
    addr[v.ch]  = v.addr;
    wdata[v.ch] = v.wdata;
    wmask[v.ch] = v.wmask;
    req[v.ch]   = ~req[v.ch];
    if (push) exp_q.push_back(v);
  endtask

  // Pops one expected record per observed ack toggle; optionally re-requests CHR.
  task automatic wait_acks(input int n, input int chr_refill, input int budget);
    logic [2:0] prev;
    logic [2:0] diff;
    int got;
    int t;
    int idx;
    int refill;
    vec_t e;
    mem_cmd_t c;
    prev   = ack;
    got    = 0;
    t      = 0;
    refill = chr_refill;
    while (got < n && t < budget) begin
      @(negedge clk);
      t++;
      if (ack !== prev) begin
        diff = ack ^ prev;
        prev = ack;
        idx  = diff[0] ? 0 : (diff[1] ? 1 : 2);
        check_output("one_ack_toggle", $countones(diff), 1);
        if (chk_timing) check_output("ack_latency", cyc, last_done_cyc + 1);
        if (exp_q.size() == 0) begin
          check_output("unexpected_ack", 32'(idx), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_output("grant_channel", 32'(idx), 32'(e.ch));
          check_output("rdata", 32'(rdata[idx]), 32'(e.rdata));
          if (cmd_rd < cmd_wr) begin
            c = cmd_log[cmd_rd];
            cmd_rd++;
            check_output("cmd_we", 32'(c.we), 32'(e.we));
            check_output("cmd_addr", 32'(c.addr), 32'(e.addr));
            check_output("cmd_wdata", 32'(c.wdata), 32'(e.wdata));
            check_output("cmd_wmask", 32'(c.wmask), 32'(e.wmask));
          end else begin
            check_output("cmd_missing", 32'(cmd_rd), 32'(cmd_wr + 1));
          end
        end
        if (idx == 0 && refill > 0) begin
          req[0] = ~req[0];
          refill--;
        end
        got++;
      end
    end
    if (got < n) check_output("ack_wait_budget", 32'(got), 32'(n));
  endtask

  initial begin
    vec_t chr_v;
    vec_t prg_v;
    vec_t aux_v;
    int t;
    int n0;

    tbl[0] = '{CH_CHR, 1'b0, 22'h000123, 16'h0000, 2'b00, 16'hBEEF};
    tbl[1] = '{CH_PRG, 1'b0, 22'h000456, 16'h0000, 2'b00, 16'h5E0C};
    tbl[2] = '{CH_PRG, 1'b1, 22'h000457, 16'h00A5, 2'b01, 16'h5E0C};
    tbl[3] = '{CH_AUX, 1'b0, 22'h3FFFFF, 16'h0000, 2'b00, 16'hA5A5};
    tbl[4] = '{CH_AUX, 1'b1, 22'h000000, 16'h1234, 2'b11, 16'hA5A5};
    tbl[5] = '{CH_CHR, 1'b0, 22'h2ABCDE, 16'h0000, 2'b00, 16'hE684};
    tbl[6] = '{CH_CHR, 1'b1, 22'h000010, 16'hFFFF, 2'b10, 16'hE684};
    chr_v  = '{CH_CHR, 1'b0, 22'h000100, 16'h0000, 2'b00, 16'h5B5A};
    prg_v  = '{CH_PRG, 1'b0, 22'h000200, 16'h0000, 2'b00, 16'h585A};
    aux_v  = '{CH_AUX, 1'b0, 22'h000300, 16'h0000, 2'b00, 16'h595A};

    reset_n = 1'b0;
    req     = '0;
    we      = '0;
    addr    = '0;
    wdata   = '0;
    wmask   = '0;
    repeat (3) @(negedge clk);
    check_output("reset_ack", 32'(ack), 0);
    check_output("reset_mem_valid", 32'(mem_valid), 0);
    check_output("reset_busy", 32'(busy), 0);
    check_output("reset_err", 32'(err), 0);
    check_output("reset_rdata", 32'(rdata[0] | rdata[1] | rdata[2]), 0);
    check_output("reset_mem_addr", 32'(mem_addr), 0);
    check_output("reset_mem_we", 32'(mem_we), 0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      apply_stimulus(tbl[i], 1'b1);
      wait_acks(1, 0, 200);
    end
    check_output("cmd_count_table", 32'(cmd_wr), 32'(NV));

    // All three at once: CHR, PRG, AUX in that order.
    @(negedge clk);
    apply_stimulus(chr_v, 1'b1);
    apply_stimulus(prg_v, 1'b1);
    apply_stimulus(aux_v, 1'b1);
    wait_acks(3, 0, 300);

    // CHR keeps re-requesting: eight CHR grants, then AUX is forced, then CHR, then PRG.
    @(negedge clk);
    apply_stimulus(chr_v, 1'b0);
    apply_stimulus(prg_v, 1'b0);
    apply_stimulus(aux_v, 1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(chr_v);
    exp_q.push_back(aux_v);
    exp_q.push_back(chr_v);
    exp_q.push_back(prg_v);
    wait_acks(11, 8, 2000);
    repeat (2) @(negedge clk);
    check_output("starve_cnt_cleared", 32'(dut.starve_cnt), 0);
    check_output("cmd_count_all", 32'(cmd_wr), 32'(NV + 14));

    // Reset while WAIT is outstanding, then a stale mem_done.
    hold_done = 1'b1;
    n0 = cmd_wr;
    apply_stimulus(tbl[0], 1'b0);
    t = 0;
    while (cmd_wr == n0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_output("reset_test_cmd_seen", 32'(cmd_wr), 32'(n0 + 1));
    repeat (3) @(negedge clk);
    check_output("busy_in_wait", 32'(busy), 1);
    reset_n = 1'b0;
    req     = '0;
    @(negedge clk);
    reset_n   = 1'b1;
    stray_req = ~stray_req;
    repeat (3) @(negedge clk);
    check_output("post_reset_ack", 32'(ack), 0);
    check_output("post_reset_busy", 32'(busy), 0);
    check_output("post_reset_rdata0", 32'(rdata[0]), 0);
    check_output("post_reset_mem_valid", 32'(mem_valid), 0);
    hold_done = 1'b0;
    cmd_rd    = cmd_wr;

    apply_stimulus(tbl[0], 1'b1);
    wait_acks(1, 0, 200);

`ifdef SDRAM_ARB_TIMEOUT_EN
    hold_done  = 1'b1;
    chk_timing = 1'b0;
    apply_stimulus('{CH_PRG, 1'b0, 22'h000456, 16'h0000, 2'b00, 16'hFFFF}, 1'b1);
    wait_acks(1, 0, 300);
    check_output("timeout_err", 32'(err), 1);
    hold_done  = 1'b0;
    chk_timing = 1'b1;
    repeat (8) @(negedge clk);
    apply_stimulus(tbl[1], 1'b1);
    wait_acks(1, 0, 200);
    check_output("err_sticky", 32'(err), 1);
`else
    check_output("err_tied_low", 32'(err), 0);
`endif

    check_output("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
